// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding and default bit period.
package uart_pkg;

    localparam int UART_CLKS_PER_BIT = 103;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs, with a configurable reset value.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b1}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_r;

    // Metastability chain: first stage may go metastable, second stage is the clean output.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_r <= RST_VAL;
            q      <= RST_VAL;
        end else begin
            meta_r <= d;
            q      <= meta_r;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling with a fixed clock-count bit period,
// parallel byte output with one-cycle valid / framing_error strobes.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       framing_error,
    output logic       busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic             rx_s;
    uart_state_e      state_r, state_nx_s;
    logic [CNT_W-1:0] cnt_r, cnt_nx_s;
    logic [2:0]       idx_r, idx_nx_s;
    logic [7:0]       shift_r, shift_nx_s;
    logic [7:0]       data_nx_s;
    logic             valid_nx_s;
    logic             ferr_nx_s;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rx_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State, timing counter, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= '0;
            idx_r         <= 3'd0;
            shift_r       <= 8'h00;
            data          <= 8'h00;
            valid         <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            cnt_r         <= cnt_nx_s;
            idx_r         <= idx_nx_s;
            shift_r       <= shift_nx_s;
            data          <= data_nx_s;
            valid         <= valid_nx_s;
            framing_error <= ferr_nx_s;
            busy          <= (state_nx_s != IDLE);
        end
    end

    // Next-state logic; strobes are decided here so they land on the sampling edge.
    always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        idx_nx_s   = idx_r;
        shift_nx_s = shift_r;
        data_nx_s  = data;
        valid_nx_s = 1'b0;
        ferr_nx_s  = 1'b0;

        case (state_r)
            IDLE: begin
                cnt_nx_s = '0;
                idx_nx_s = 3'd0;
                if (!rx_s) begin
                    state_nx_s = START;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            START: begin
                if (cnt_r == HALF_LAST) begin
                    cnt_nx_s = '0;
                    // A line already back high at mid-start-bit was a glitch.
                    if (rx_s) begin
                        state_nx_s = IDLE;
                    end else begin
                        state_nx_s = DATA;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s   = '0;
                    shift_nx_s = {rx_s, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        idx_nx_s   = 3'd0;
                        state_nx_s = STOP;
                    end else begin
                        idx_nx_s = idx_r + 3'd1;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt_r == BIT_LAST) begin
                    cnt_nx_s = '0;
                    if (rx_s) begin
                        data_nx_s  = shift_r;
                        valid_nx_s = 1'b1;
                        state_nx_s = IDLE;
                    end else begin
                        ferr_nx_s  = 1'b1;
                        state_nx_s = BREAK;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_W'(1);
                end
            end
            BREAK: begin
                cnt_nx_s = '0;
                if (rx_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = BREAK;
                end
            end
            default: begin
                state_nx_s = IDLE;
                cnt_nx_s   = '0;
                idx_nx_s   = 3'd0;
            end
        endcase
    end

endmodule
